// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a two-flop input synchronizer.
// Bit timing comes from CLKS_PER_BIT = FREQ/BAUD, which must be in 4..255.
// Optional feature: define UART_RX_MAJORITY_EN to take each sample as a
// 2-of-3 vote around the nominal sample point instead of a single value.
`timescale 1ns/1ps

module uart_rx #(
  parameter int FREQ = 27000000,
  parameter int BAUD = 3000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;

`ifdef UART_RX_MAJORITY_EN
  // The vote needs one extra clock, so decisions land one count later and
  // the counter resumes at 1 to keep the following bit's timing unchanged.
  localparam logic [7:0] START_DECIDE = 8'(HALF);
  localparam logic [7:0] BIT_DECIDE   = 8'(CLKS_PER_BIT);
  localparam logic [7:0] RESUME_CNT   = 8'd1;
`else
  localparam logic [7:0] START_DECIDE = 8'(HALF - 1);
  localparam logic [7:0] BIT_DECIDE   = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] RESUME_CNT   = 8'd0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  data_reg, data_next;
  logic        valid_reg, valid_next;
  logic        ferr_reg, ferr_next;
  logic        rx_m, rx_s, rx_prev;
  logic        sample;

  // Two-flop synchronizer plus one-clock history for start-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_reg;

  // Keep the two previous synchronized values (target-1, target) for the vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_reg <= 2'b11;
    end else begin
      hist_reg <= {hist_reg[0], rx_s};
    end
  end

  assign sample = (hist_reg[1] & hist_reg[0]) |
                  (hist_reg[1] & rx_s) |
                  (hist_reg[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  // State, counters, shift register and registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 8'd0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'd0;
      data_reg    <= 8'h00;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
    end
  end

  // Next-state logic: frame tracking, bit sampling and stop-bit checking.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + 8'd1;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    data_next    = data_reg;
    valid_next   = 1'b0;
    ferr_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = 8'd0;
        // Only a 1->0 transition starts a frame; a line stuck low does not.
        if (rx_prev && !rx_s) begin
          state_next = START;
        end
      end
      START: begin
        if (cnt_reg == START_DECIDE) begin
          if (!sample) begin
            state_next   = DATA;
            cnt_next     = RESUME_CNT;
            bit_idx_next = 3'd0;
          end else begin
            // Start bit did not hold: treat as a glitch.
            state_next = IDLE;
            cnt_next   = 8'd0;
          end
        end
      end
      DATA: begin
        if (cnt_reg == BIT_DECIDE) begin
          shift_next   = {sample, shift_reg[7:1]};
          cnt_next     = RESUME_CNT;
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_reg == BIT_DECIDE) begin
          state_next = IDLE;
          cnt_next   = 8'd0;
          if (sample) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
          end else begin
            ferr_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = ferr_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at the default 9 clocks per bit.
`timescale 1ns/1ps

module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Free-running event counters maintained by the monitor.
  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  int         busy_cnt  = 0;
  int         both_cnt  = 0;
  logic [7:0] cap [0:63];

  uart_rx #(.FREQ(27000000), .BAUD(3000000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Monitor: count pulse cycles and capture data on each valid.
  always @(negedge clk) begin
    if (valid) begin
      cap[valid_cnt % 64] <= data;
      valid_cnt <= valid_cnt + 1;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (valid && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic send_bit(input logic b, input bit glitch);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rx = (glitch && i == 4) ? ~b : b;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(stop, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    $display("reset: data=%02h valid=%b ferr=%b busy=%b", data, valid, frame_err, busy);
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%02h exp=00", data); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_single();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b1, 1'b0);
    idle(8);
    $display("frame 0x55: data=%02h valid_cycles=%0d ferr_cycles=%0d", data, valid_cnt - v0, ferr_cnt - f0);
    total++; if (data !== 8'h55) begin bad++; $display("FAIL single_data got=%02h exp=55", data); end
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL single_valid_cycles got=%0d exp=1", valid_cnt - v0); end
    total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL single_ferr got=%0d exp=0", ferr_cnt - f0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(8);
    $display("frames 0xA5,0x3C: valid_cycles=%0d first=%02h second=%02h", valid_cnt - v0, cap[v0 % 64], cap[(v0 + 1) % 64]);
    total++; if (valid_cnt - v0 !== 2) begin bad++; $display("FAIL b2b_valid_cycles got=%0d exp=2", valid_cnt - v0); end
    total++; if (cap[v0 % 64] !== 8'hA5) begin bad++; $display("FAIL b2b_first got=%02h exp=A5", cap[v0 % 64]); end
    total++; if (cap[(v0 + 1) % 64] !== 8'h3C) begin bad++; $display("FAIL b2b_second got=%02h exp=3C", cap[(v0 + 1) % 64]); end
    total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL b2b_ferr got=%0d exp=0", ferr_cnt - f0); end
  endtask

  task automatic test_start_glitch();
    int v0, f0, b0;
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b0;
    idle(25);
    $display("start glitch: busy_cycles=%0d valid_cycles=%0d ferr_cycles=%0d", busy_cnt - b0, valid_cnt - v0, ferr_cnt - f0);
    total++; if (busy_cnt - b0 <= 0) begin bad++; $display("FAIL glitch_busy_rose got=%0d exp>0", busy_cnt - b0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_after got=%b exp=0", busy); end
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", valid_cnt - v0); end
    total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0); end
  endtask

  task automatic test_frame_error();
    int v0, f0;
    send_frame(8'h55, 1'b1, 1'b0);
    idle(8);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h81, 1'b0, 1'b0);
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b0;
    idle(10);
    $display("frame 0x81 bad stop: data=%02h ferr_cycles=%0d valid_cycles=%0d", data, ferr_cnt - f0, valid_cnt - v0);
    total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_cycles got=%0d exp=1", ferr_cnt - f0); end
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL ferr_valid got=%0d exp=0", valid_cnt - v0); end
    total++; if (data !== 8'h55) begin bad++; $display("FAIL ferr_data_hold got=%02h exp=55", data); end
    v0 = valid_cnt;
    send_frame(8'h12, 1'b1, 1'b0);
    idle(8);
    $display("frame 0x12: data=%02h valid_cycles=%0d", data, valid_cnt - v0);
    total++; if (data !== 8'h12) begin bad++; $display("FAIL after_ferr_data got=%02h exp=12", data); end
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL after_ferr_valid got=%0d exp=1", valid_cnt - v0); end
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL overlap got=%0d exp=0", both_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    int v0, f0;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    repeat (4) begin @(negedge clk); rx = 1'b1; end
    v0 = valid_cnt; f0 = ferr_cnt;
    #2 rst = 1'b1;
    #1;
    $display("reset mid-frame: data=%02h valid=%b ferr=%b busy=%b", data, valid, frame_err, busy);
    total++; if (data !== 8'h00) begin bad++; $display("FAIL midrst_data got=%02h exp=00", data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL midrst_ferr got=%b exp=0", frame_err); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(60);
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL midrst_no_valid got=%0d exp=0", valid_cnt - v0); end
    total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL midrst_no_ferr got=%0d exp=0", ferr_cnt - f0); end
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(8);
    $display("frame 0x0F after reset: data=%02h", data);
    total++; if (data !== 8'h0F) begin bad++; $display("FAIL midrst_next_data got=%02h exp=0F", data); end
  endtask

  task automatic test_majority();
    int v0;
    logic [7:0] exp_data;
`ifdef UART_RX_MAJORITY_EN
    exp_data = 8'hC3;
`else
    exp_data = 8'h3C;
`endif
    v0 = valid_cnt;
    send_frame(8'hC3, 1'b1, 1'b1);
    idle(8);
    $display("frame 0xC3 mid-bit glitches: data=%02h valid_cycles=%0d", data, valid_cnt - v0);
    total++; if (data !== exp_data) begin bad++; $display("FAIL majority_data got=%02h exp=%02h", data, exp_data); end
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL majority_valid got=%0d exp=1", valid_cnt - v0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_start_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_majority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter FREQ, default 27000000: input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 3000000: line bit rate in baud.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port data, output, 8 bits: last correctly framed byte received.
REQ-007 SHALL have port valid, output, 1 bit: one-clock pulse when data has been updated.
REQ-008 SHALL have port frame_err, output, 1 bit: one-clock pulse when the stop bit is sampled low.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-010 SHALL define CLKS_PER_BIT = FREQ/BAUD (integer divide) and HALF = CLKS_PER_BIT/2; CLKS_PER_BIT SHALL be 4..255, and the bit counter SHALL be 8 bits wide.
REQ-011 SHALL pass rx through a two-flop synchronizer (rx_s); all decisions SHALL use rx_s only.
REQ-012 SHALL frame 8N1: start bit 0, 8 data bits LSB first, one stop bit 1; no parity.
REQ-013 SHALL implement states IDLE, START, DATA and STOP.
REQ-014 IDLE: on a falling edge of rx_s (previous 1, current 0), SHALL clear the counter and enter START; a line held low without an edge SHALL NOT start a frame.
REQ-015 START: SHALL sample when the counter reaches HALF-1; if the sample is 0, SHALL clear the counter and enter DATA; if it is 1 (glitch), SHALL return to IDLE with no pulse.
REQ-016 DATA: SHALL sample when the counter reaches CLKS_PER_BIT-1, then clear the counter.
REQ-017 DATA: each sample SHALL shift into bit 7 of the shift register, moving earlier bits toward bit 0.
REQ-018 DATA: after the 8th sample, SHALL enter STOP; the 3-bit bit index SHALL wrap 7->0.
REQ-019 STOP: SHALL sample at counter CLKS_PER_BIT-1 and go to IDLE on that clock.
REQ-020 STOP: if the sample is 1, data SHALL load the shift register and valid SHALL pulse on the next clock.
REQ-021 STOP: if the sample is 0, frame_err SHALL pulse on the next clock and data SHALL hold its previous value.
REQ-022 After a stop bit sampled low, SHALL require rx_s to return high before any new start (follows from edge detection in REQ-014).
REQ-023 valid and frame_err SHALL never be high together, and each SHALL be high for exactly one clock per frame.
REQ-024 data SHALL be stable at all times except the clock on which valid rises.
REQ-025 Back-to-back frames, with a start edge immediately after the stop bit, SHALL be received with no lost bytes.

Reset
REQ-026 rst high SHALL asynchronously force: state IDLE, counter 0, shift register 0, data 8'h00, valid 0, frame_err 0, busy 0, synchronizer flops and edge history 1.
REQ-027 Reset mid-frame SHALL discard the partial byte and produce no pulse; after release, reception SHALL resume only on a new falling edge.

Configuration
REQ-028 With macro UART_RX_MAJORITY_EN defined, every sample (start, data, stop) SHALL be the 2-of-3 majority of rx_s at counter values target-1, target and target+1; the decision SHALL be taken at target+1, and the next bit's counting SHALL be unchanged.
REQ-029 Without UART_RX_MAJORITY_EN, each sample SHALL be the single value of rx_s at the target count, and no vote logic SHALL be synthesized.

Verification
REQ-030 Defaults (CLKS_PER_BIT=9), byte 0x55 sent at exact baud -> data=0x55, valid one clock, frame_err 0, busy low afterward.
REQ-031 Frames 0xA5 then 0x3C sent back-to-back -> two valid pulses, data 0xA5 then 0x3C, no frame_err.
REQ-032 rx low for 2 clocks then high -> busy rises, returns to IDLE after START, no valid and no frame_err.
REQ-033 Byte 0x81 with stop bit 0, following a good 0x55 -> frame_err one clock, data stays 0x55, next good frame 0x12 received.
REQ-034 rst pulsed during data bit 4 of 0xFF -> all outputs reset, no pulse, next frame 0x0F -> data=0x0F.
REQ-035 With UART_RX_MAJORITY_EN, a 1-clock inverted glitch at the mid-sample of each bit of 0xC3 -> data=0xC3; without the macro, the same stimulus corrupts data.
